layer_code_dbuf: RTL

LAYER_CODE_DBUF -- requirements
Module: layer_code_dbuf

---
 rtl/layer_code_dbuf_pkg.sv | 27 ++
 rtl/ws2812_bit_timer.sv | 44 ++++
 rtl/layer_code_dbuf.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/layer_code_dbuf_pkg.sv
// Shared engine state encoding and sizing helpers for the double-buffered
// WS2812 serialiser.
package layer_code_dbuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } eng_state_t;

  localparam int DEF_NUM_LEDS      = 64;
  localparam int DEF_BYTES_PER_LED = 4;
  localparam int ADDR_W            = $clog2(DEF_NUM_LEDS);
  localparam int WORD_W            = DEF_BYTES_PER_LED * 8;

  function automatic int calc_addr_w(input int num_leds);
    return (num_leds > 1) ? $clog2(num_leds) : 1;
  endfunction

  function automatic int calc_word_w(input int bytes_per_led);
    return bytes_per_led * 8;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Phase counter for HIGH, LOW and LATCH; zero-length requests are stretched
// to one cycle so every phase is visible on the line.
module ws2812_bit_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load_bit,
  input  logic        i_bit_val,
  input  logic        i_load_low,
  input  logic        i_load_latch,
  input  logic [7:0]  i_t0h,
  input  logic [7:0]  i_t0l,
  input  logic [7:0]  i_t1h,
  input  logic [7:0]  i_t1l,
  input  logic [15:0] i_rst_cnt,
  output logic        o_done
);

  logic [15:0] r_cnt;
  logic [7:0]  r_low_len;

  function automatic logic [7:0] clamp8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  // The LOW length is captured together with HIGH so a bit never mixes pairs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_low_len <= '0;
    end else if (i_load_bit) begin
      r_cnt     <= {8'd0, clamp8(i_bit_val ? i_t1h : i_t0h)};
      r_low_len <= clamp8(i_bit_val ? i_t1l : i_t0l);
    end else if (i_load_low) begin
      r_cnt <= {8'd0, r_low_len};
    end else if (i_load_latch) begin
      r_cnt <= (i_rst_cnt == 16'd0) ? 16'd1 : i_rst_cnt;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_done = (r_cnt == 16'd1);

endmodule

// File: rtl/layer_code_dbuf.sv
// Double-buffered WS2812 serialiser: the writer fills the back bank while the
// engine streams the front bank; banks swap only between frames.
module layer_code_dbuf
  import layer_code_dbuf_pkg::*;
#(
  parameter int  NUM_LEDS      = 64,
  parameter int  BYTES_PER_LED = 4,
  parameter int  MSB_FIRST     = 1,
  localparam int LADDR_W       = calc_addr_w(NUM_LEDS),
  localparam int LWORD_W       = calc_word_w(BYTES_PER_LED)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     wr_en_in,
  input  logic                     wr_done_in,
  input  logic [LADDR_W-1:0]       wr_addr_in,
  input  logic [7:0]               wr_data_in,
  input  logic [BYTES_PER_LED-1:0] wr_byte_en_in,
  input  logic [7:0]               t0h_cnt_in,
  input  logic [7:0]               t0l_cnt_in,
  input  logic [7:0]               t1h_cnt_in,
  input  logic [7:0]               t1l_cnt_in,
  input  logic [15:0]              rst_cnt_in,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     swap_pend_out,
  output logic                     ws2812_code_out
);

  localparam int BIT_W = $clog2(LWORD_W);
  // {bank, address} indexing needs a power-of-two stride per bank.
  localparam int DEPTH = 2 << LADDR_W;
  localparam logic [LADDR_W:0]   ADDR_LIMIT = (LADDR_W+1)'(NUM_LEDS);
  localparam logic [LADDR_W-1:0] LAST_LED   = LADDR_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(LWORD_W - 1);

  logic [LWORD_W-1:0] r_mem [DEPTH];
  logic [LWORD_W-1:0] r_rd_data;
  logic [LWORD_W-1:0] r_shift;
  eng_state_t         r_state;
  eng_state_t         w_next;
  logic               r_bank_sel;
  logic               r_swap_pend;
  logic [LADDR_W-1:0] r_led_idx;
  logic [BIT_W-1:0]   r_bit_idx;

  logic w_swap, w_wr_ok, w_wr_bank, w_done, w_last_bit, w_last_led, w_bit_val;
  logic w_load_bit, w_load_low, w_load_latch;

  assign w_swap     = (r_state == ST_IDLE) && r_swap_pend;
  assign w_wr_ok    = wr_en_in && ({1'b0, wr_addr_in} < ADDR_LIMIT);
  // During the swap cycle the old front is already the new back bank.
  assign w_wr_bank  = w_swap ? r_bank_sel : ~r_bank_sel;
  assign w_last_bit = (r_bit_idx == LAST_BIT);
  assign w_last_led = (r_led_idx == LAST_LED);

  always_ff @(posedge clk_in) begin
    if (w_wr_ok) begin
      for (int b = 0; b < BYTES_PER_LED; b++) begin
        if (wr_byte_en_in[b]) r_mem[{w_wr_bank, wr_addr_in}][b*8 +: 8] <= wr_data_in;
      end
    end
    if (r_state == ST_FETCH) r_rd_data <= r_mem[{r_bank_sel, r_led_idx}];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_bank_sel  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_led_idx   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
    end else begin
      r_state <= w_next;
      if (w_swap) begin
        r_bank_sel  <= ~r_bank_sel;
        r_swap_pend <= wr_done_in;
        r_led_idx   <= '0;
      end else if (wr_done_in) begin
        r_swap_pend <= 1'b1;
      end
      if (r_state == ST_WAIT) begin
        r_shift   <= r_rd_data;
        r_bit_idx <= '0;
      end else if (r_state == ST_LOW && w_done) begin
        if (!w_last_bit) begin
          r_shift   <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
          r_bit_idx <= r_bit_idx + 1'b1;
        end else if (!w_last_led) begin
          r_led_idx <= r_led_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_swap_pend) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_HIGH;
      ST_HIGH:  if (w_done) w_next = ST_LOW;
      ST_LOW: begin
        if (w_done) begin
          if (!w_last_bit)      w_next = ST_HIGH;
          else if (w_last_led)  w_next = ST_LATCH;
          else                  w_next = ST_FETCH;
        end
      end
      ST_LATCH: if (w_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out        = (r_state != ST_IDLE);
    ws2812_code_out = (r_state == ST_HIGH);
    frame_done_out  = (r_state == ST_LATCH) && w_done;
    w_load_bit      = (r_state == ST_WAIT) || (r_state == ST_LOW && w_done && !w_last_bit);
    w_load_low      = (r_state == ST_HIGH) && w_done;
    w_load_latch    = (r_state == ST_LOW) && w_done && w_last_bit && w_last_led;
    // Next bit: first word bit when loading, else the one after the shift.
    if (r_state == ST_WAIT)
      w_bit_val = (MSB_FIRST != 0) ? r_rd_data[LWORD_W-1] : r_rd_data[0];
    else
      w_bit_val = (MSB_FIRST != 0) ? r_shift[LWORD_W-2] : r_shift[1];
  end

  assign swap_pend_out = r_swap_pend;

  ws2812_bit_timer u_timer (
    .i_clk        (clk_in),
    .i_rst_n      (rst_n_in),
    .i_load_bit   (w_load_bit),
    .i_bit_val    (w_bit_val),
    .i_load_low   (w_load_low),
    .i_load_latch (w_load_latch),
    .i_t0h        (t0h_cnt_in),
    .i_t0l        (t0l_cnt_in),
    .i_t1h        (t1h_cnt_in),
    .i_t1l        (t1l_cnt_in),
    .i_rst_cnt    (rst_cnt_in),
    .o_done       (w_done)
  );

endmodule
